// File: rtl/keyboard_regs.sv
// PS/2 keyboard receiver with a scancode FIFO and a STATUS/DATA/LAST register window.
// Latency: register reads are combinational; a frame is pushed 3 clk edges after its stop-bit ps2_clk fall.
// Backpressure: none toward the keyboard; a push into a full FIFO is dropped and sets sticky OVF.
// Optional feature: define KB_PARITY_CHECK_EN to enforce odd parity and report PERR.
module keyboard_regs #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kb_read,
  input  logic [7:0]  kb_addr,
  output logic [31:0] kb_rdata,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Synchronizer and edge-detect state
  logic ps2_clk_s1_q, ps2_clk_s1_d;
  logic ps2_clk_s2_q, ps2_clk_s2_d;
  logic ps2_clk_prev_q, ps2_clk_prev_d;
  logic ps2_dat_s1_q, ps2_dat_s1_d;
  logic ps2_dat_s2_q, ps2_dat_s2_d;
  logic ps2_fall;

  // Receive FSM state
  rx_state_t  rx_state_q, rx_state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       push_vld;
  logic [7:0] push_dat;
  logic       perr_set;

  // FIFO and sticky status state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;

  logic       full, nonempty, pop, push_ok, ovf_set, status_rd;
  logic [7:0] head;
  logic       addr_lsb_unused;

  // Byte lane bits of the address do not take part in decode
  assign addr_lsb_unused = ^kb_addr[1:0];

  // Synchronizers, falling-edge detect, receive FSM and idle timeout
  always_comb begin
    ps2_clk_s1_d   = ps2_clk;
    ps2_clk_s2_d   = ps2_clk_s1_q;
    ps2_clk_prev_d = ps2_clk_s2_q;
    ps2_dat_s1_d   = ps2_data;
    ps2_dat_s2_d   = ps2_dat_s1_q;
    ps2_fall       = ps2_clk_prev_q & ~ps2_clk_s2_q;

    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = tmo_q;
    push_vld   = 1'b0;
    push_dat   = shift_q;
    perr_set   = 1'b0;

    if (ps2_fall) begin
      tmo_d = '0;
      case (rx_state_q)
        ST_IDLE: begin
          if (!ps2_dat_s2_q) begin
            rx_state_d = ST_DATA;
            bit_cnt_d  = 3'd0;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so shift in from the top
          shift_d = {ps2_dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_d   = ps2_dat_s2_q;
          rx_state_d = ST_STOP;
        end
        ST_STOP: begin
          rx_state_d = ST_IDLE;
`ifdef KB_PARITY_CHECK_EN
          push_vld = ps2_dat_s2_q & (^{shift_q, parity_q});
          perr_set = ~push_vld;
`else
          push_vld = ps2_dat_s2_q;
`endif
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end else if (rx_state_q != ST_IDLE) begin
      // A stalled partial frame is abandoned silently; PERR is not touched
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        rx_state_d = ST_IDLE;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // FIFO push/pop, overflow handling and sticky status bits
  always_comb begin
    full      = (count_q == CW'(FIFO_DEPTH));
    nonempty  = (count_q != '0);
    head      = mem_q[rd_ptr_q];
    status_rd = kb_read && (kb_addr[7:2] == 6'd0);
    pop       = kb_read && (kb_addr[7:2] == 6'd1) && nonempty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok   = push_vld && (!full || pop);
    ovf_set   = push_vld && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      last_d          = push_dat;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen in one cycle
    ovf_d  = (ovf_q  & ~status_rd) | ovf_set;
    perr_d = (perr_q & ~status_rd) | perr_set;
  end

  // Register read mux, purely combinational from address and state
  always_comb begin
    kb_rdata = 32'd0;
    case (kb_addr[7:2])
      6'd0: kb_rdata = {20'd0, 4'(count_q), 4'd0, perr_q, ovf_q, full, nonempty};
      6'd1: kb_rdata = nonempty ? {23'd0, 1'b1, head} : 32'd0;
      6'd2: kb_rdata = {24'd0, last_q};
      default: kb_rdata = 32'd0;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_dat_s1_q   <= 1'b1;
      ps2_dat_s2_q   <= 1'b1;
      rx_state_q     <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      parity_q       <= 1'b0;
      tmo_q          <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      ps2_clk_s1_q   <= ps2_clk_s1_d;
      ps2_clk_s2_q   <= ps2_clk_s2_d;
      ps2_clk_prev_q <= ps2_clk_prev_d;
      ps2_dat_s1_q   <= ps2_dat_s1_d;
      ps2_dat_s2_q   <= ps2_dat_s2_d;
      rx_state_q     <= rx_state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      tmo_q          <= tmo_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      last_q         <= last_d;
      ovf_q          <= ovf_d;
      perr_q         <= perr_d;
    end
  end

endmodule
